// File: rtl/cart_pkg.sv
// Shared cartridge header definitions: header offsets, snoop FSM states and size-code limits.
package cart_pkg;

   localparam logic [14:0] HDR_FIRST = 15'h134;
   localparam logic [14:0] HDR_TYPE  = 15'h147;
   localparam logic [14:0] HDR_ROM   = 15'h148;
   localparam logic [14:0] HDR_RAM   = 15'h149;
   localparam logic [14:0] HDR_CK    = 15'h14D;

   localparam logic [7:0] ROM_SIZE_MAX = 8'd6;
   localparam logic [7:0] RAM_SIZE_MAX = 8'd3;

   typedef enum logic [1:0] {IDLE, COLLECT, DONE, FAIL} hdr_state_t;

   function automatic logic in_hdr(input logic [14:0] a);
      return (a >= HDR_FIRST) && (a <= HDR_CK);
   endfunction

endpackage

// File: rtl/cart_hdr_cksum.sv
// Header checksum accumulator over 0x134..0x14C with first-read-only seen mask.
// Compiled only when CART_HDR_CHECKSUM_EN is defined.
`ifdef CART_HDR_CHECKSUM_EN
module cart_hdr_cksum (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] i_byte,
   input  logic [4:0] i_idx,
   input  logic       i_stb,
   input  logic       i_clr,
   output logic [7:0] o_acc,
   output logic       o_all_seen
);

   logic [24:0] r_seen, w_seen_base, w_seen_nxt;
   logic [7:0]  r_acc, w_acc_base, w_acc_nxt;

   // Outputs look ahead to include the byte strobed this cycle, so the
   // parent can decide completion on the same edge that captures it.
   always_comb begin
      w_seen_base = i_clr ? '0 : r_seen;
      w_acc_base  = i_clr ? '0 : r_acc;
      w_seen_nxt  = w_seen_base;
      w_acc_nxt   = w_acc_base;
      if (i_stb && !w_seen_base[i_idx]) begin
         w_seen_nxt[i_idx] = 1'b1;
         w_acc_nxt         = w_acc_base - i_byte - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_seen <= '0;
         r_acc  <= '0;
      end else begin
         r_seen <= w_seen_nxt;
         r_acc  <= w_acc_nxt;
      end
   end

   assign o_acc      = w_acc_nxt;
   assign o_all_seen = &w_seen_nxt;

endmodule
`endif

// File: rtl/cart_header_snoop.sv
// Passive snooper of cartridge ROM header reads; latches type/size codes and gates MBC enable.
// Optional header checksum verification: define CART_HDR_CHECKSUM_EN.
module cart_header_snoop
   import cart_pkg::*;
#(
   parameter int unsigned LOCK_ON_DONE = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [14:0] iadr,
   input  logic [7:0]  data,
   input  logic        read,
   input  logic        ics_rom,
   output logic [7:0]  cart_type,
   output logic [2:0]  rom_size,
   output logic [1:0]  ram_size,
   output logic        size_err,
   output logic        hdr_valid,
   output logic        hdr_bad,
   output logic        busy
);

   logic [14:0] r_hadr;
   logic [7:0]  r_hdata;
   logic        r_pread, r_hrom;
   hdr_state_t  r_state;
   logic [7:0]  r_type;
   logic [2:0]  r_rom;
   logic [1:0]  r_ram;
   logic        r_rom_big, r_ram_big, r_got_type, r_got_rom, r_got_ram;
   logic        r_valid, r_busy;
   logic        w_complete, w_proc, w_term, w_restart, w_take, w_all;
   logic        w_type_new, w_rom_new, w_ram_new;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pread <= 1'b0;
         r_hrom  <= 1'b0;
         r_hadr  <= '0;
         r_hdata <= '0;
      end else begin
         r_pread <= read;
         if (read && ics_rom) begin
            r_hadr  <= iadr;
            r_hdata <= data;
            r_hrom  <= 1'b1;
         end else if (w_complete) begin
            r_hrom  <= 1'b0;
         end
      end
   end

   assign w_complete = r_pread && !read;
   assign w_proc     = w_complete && r_hrom && in_hdr(r_hadr);
   assign w_term     = (r_state == DONE) || (r_state == FAIL);
   assign w_restart  = w_proc && w_term && (LOCK_ON_DONE == 0) && (r_hadr == HDR_FIRST);
   assign w_take     = (w_proc && !w_term) || w_restart;

   // A restart makes every "already seen" flag read as clear for this byte.
   assign w_type_new = w_take && (r_hadr == HDR_TYPE) && !(r_got_type && !w_restart);
   assign w_rom_new  = w_take && (r_hadr == HDR_ROM)  && !(r_got_rom  && !w_restart);
   assign w_ram_new  = w_take && (r_hadr == HDR_RAM)  && !(r_got_ram  && !w_restart);

`ifdef CART_HDR_CHECKSUM_EN
   logic [7:0] r_ck, w_acc, w_ck_val;
   logic       r_seen_ck, r_bad, w_ck_new, w_all_seen, w_ok;

   // 0x134..0x14C map to 0..24 modulo 32 using only the low address bits.
   cart_hdr_cksum u_cksum (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_byte     (r_hdata),
      .i_idx      (r_hadr[4:0] - 5'd20),
      .i_stb      (w_take && (r_hadr != HDR_CK)),
      .i_clr      (w_restart),
      .o_acc      (w_acc),
      .o_all_seen (w_all_seen)
   );

   assign w_ck_new = w_take && (r_hadr == HDR_CK) && !(r_seen_ck && !w_restart);
   assign w_ck_val = w_ck_new ? r_hdata : r_ck;
   assign w_all    = w_all_seen && (w_ck_new || (r_seen_ck && !w_restart));
   assign w_ok     = (w_acc == w_ck_val);
   assign hdr_bad  = r_bad;
`else
   assign w_all    = (w_type_new || (r_got_type && !w_restart)) &&
                     (w_rom_new  || (r_got_rom  && !w_restart)) &&
                     (w_ram_new  || (r_got_ram  && !w_restart));
   assign hdr_bad  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_type     <= '0;
         r_rom      <= '0;
         r_ram      <= '0;
         r_rom_big  <= 1'b0;
         r_ram_big  <= 1'b0;
         r_got_type <= 1'b0;
         r_got_rom  <= 1'b0;
         r_got_ram  <= 1'b0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
`ifdef CART_HDR_CHECKSUM_EN
         r_ck       <= '0;
         r_seen_ck  <= 1'b0;
         r_bad      <= 1'b0;
`endif
      end else begin
         if (w_restart) begin
            r_type     <= '0;
            r_rom      <= '0;
            r_ram      <= '0;
            r_rom_big  <= 1'b0;
            r_ram_big  <= 1'b0;
            r_got_type <= 1'b0;
            r_got_rom  <= 1'b0;
            r_got_ram  <= 1'b0;
`ifdef CART_HDR_CHECKSUM_EN
            r_seen_ck  <= 1'b0;
`endif
         end
         if (w_type_new) begin
            r_type     <= r_hdata;
            r_got_type <= 1'b1;
         end
         if (w_rom_new) begin
            r_rom      <= r_hdata[2:0];
            r_rom_big  <= r_hdata > ROM_SIZE_MAX;
            r_got_rom  <= 1'b1;
         end
         if (w_ram_new) begin
            r_ram      <= r_hdata[1:0];
            r_ram_big  <= r_hdata > RAM_SIZE_MAX;
            r_got_ram  <= 1'b1;
         end
`ifdef CART_HDR_CHECKSUM_EN
         if (w_ck_new) begin
            r_ck      <= r_hdata;
            r_seen_ck <= 1'b1;
         end
`endif
         if (w_take) begin
            if (w_all) begin
`ifdef CART_HDR_CHECKSUM_EN
               r_state <= w_ok ? DONE : FAIL;
               r_valid <= w_ok;
               r_bad   <= !w_ok;
`else
               r_state <= DONE;
               r_valid <= 1'b1;
`endif
               r_busy  <= 1'b0;
            end else begin
               r_state <= COLLECT;
               r_valid <= 1'b0;
               r_busy  <= 1'b1;
`ifdef CART_HDR_CHECKSUM_EN
               r_bad   <= 1'b0;
`endif
            end
         end
      end
   end

   assign cart_type = r_type;
   assign rom_size  = r_rom;
   assign ram_size  = r_ram;
   assign size_err  = r_rom_big || r_ram_big;
   assign hdr_valid = r_valid;
   assign busy      = r_busy;

endmodule

// File: tb/tb_cart_header_snoop.sv
// Self-checking bench for cart_header_snoop against a first-read header model.
module tb_cart_header_snoop;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [14:0] iadr = '0;
   logic [7:0]  data = '0;
   logic        read = 1'b0;
   logic        ics_rom = 1'b0;
   logic [7:0]  cart_type;
   logic [2:0]  rom_size;
   logic [1:0]  ram_size;
   logic        size_err, hdr_valid, hdr_bad, busy;

   int n_pass = 0;
   int n_chk  = 0;

   bit         m_seen[26];
   logic [7:0] m_val[26];
   logic [7:0] hdr[26];
   int         ord[26];

   always #5 clk = ~clk;

   cart_header_snoop #(.LOCK_ON_DONE(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .iadr      (iadr),
      .data      (data),
      .read      (read),
      .ics_rom   (ics_rom),
      .cart_type (cart_type),
      .rom_size  (rom_size),
      .ram_size  (ram_size),
      .size_err  (size_err),
      .hdr_valid (hdr_valid),
      .hdr_bad   (hdr_bad),
      .busy      (busy)
   );

   function automatic bit m_complete();
`ifdef CART_HDR_CHECKSUM_EN
      for (int i = 0; i < 26; i++) if (!m_seen[i]) return 1'b0;
      return 1'b1;
`else
      return m_seen[19] && m_seen[20] && m_seen[21];
`endif
   endfunction

   // Header checksum: 0 - sum(byte + 1) over 0x134..0x14C, modulo 256.
   function automatic logic [7:0] ck_of_model();
      int s = 0;
      for (int i = 0; i < 25; i++) s += int'(m_val[i]) + 1;
      return 8'((256 - (s % 256)) % 256);
   endfunction

   function automatic bit m_ok();
`ifdef CART_HDR_CHECKSUM_EN
      return m_val[25] == ck_of_model();
`else
      return 1'b1;
`endif
   endfunction

   function automatic bit m_any();
      for (int i = 0; i < 26; i++) if (m_seen[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 26; i++) begin
         m_seen[i] = 1'b0;
         m_val[i]  = '0;
      end
   endtask

   task automatic m_read(input logic [14:0] a, input logic [7:0] d);
      int i;
      if (a >= 15'h134 && a <= 15'h14D && !m_complete()) begin
         i = int'(a) - 'h134;
         if (!m_seen[i]) begin
            m_seen[i] = 1'b1;
            m_val[i]  = d;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag);
      bit c, ok;
      logic [7:0] t, r, m;
      c  = m_complete();
      ok = m_ok();
      t  = m_val[19];
      r  = m_val[20];
      m  = m_val[21];
      chk({tag, ".type"},  cart_type, m_seen[19] ? t : 8'h00);
      chk({tag, ".rom"},   {5'b0, rom_size}, m_seen[20] ? {5'b0, r[2:0]} : 8'h00);
      chk({tag, ".ram"},   {6'b0, ram_size}, m_seen[21] ? {6'b0, m[1:0]} : 8'h00);
      chk({tag, ".serr"},  {7'b0, size_err},
          {7'b0, (m_seen[20] && r > 8'd6) || (m_seen[21] && m > 8'd3)});
      chk({tag, ".valid"}, {7'b0, hdr_valid}, {7'b0, c && ok});
      chk({tag, ".bad"},   {7'b0, hdr_bad},   {7'b0, c && !ok});
      chk({tag, ".busy"},  {7'b0, busy},      {7'b0, m_any() && !c});
   endtask

   // Entered at a falling edge; read held for two clocks, then one low clock completes it.
   task automatic rd(input logic [14:0] a, input logic [7:0] d, input bit drop, input string tag);
      iadr = a; data = d; ics_rom = 1'b1; read = 1'b1;
      @(negedge clk);
      if (drop) begin
         ics_rom = 1'b0; iadr = 15'($urandom); data = 8'($urandom);
      end
      @(negedge clk);
      read = 1'b0; ics_rom = 1'b0; iadr = 15'($urandom); data = 8'($urandom);
      @(negedge clk);
      m_read(a, d);
      chk_all(tag);
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0; read = 1'b0; ics_rom = 1'b0;
      #1;
      m_clear();
      chk_all(tag);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic mk_hdr(input logic [7:0] t, input logic [7:0] r, input logic [7:0] m, input bit corrupt);
      int s = 0;
      for (int i = 0; i < 25; i++) hdr[i] = 8'($urandom);
      hdr[19] = t; hdr[20] = r; hdr[21] = m;
      for (int i = 0; i < 25; i++) s += int'(hdr[i]) + 1;
      hdr[25] = 8'((256 - (s % 256)) % 256 + (corrupt ? 1 : 0));
   endtask

   task automatic rd_seq(input string tag);
      for (int i = 0; i < 26; i++)
         rd(15'(15'h134 + i), hdr[i], i == 19, $sformatf("%s%0d", tag, i));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      do_reset("rst0");

      mk_hdr(8'h01, 8'h05, 8'h03, 1'b0);
      rd_seq("seq");

      do_reset("rst1");
      mk_hdr(8'h01, 8'h05, 8'h03, 1'b1);
      rd_seq("bad");

      do_reset("rst2");
      mk_hdr(8'h01, 8'h05, 8'h03, 1'b0);
      for (int i = 25; i >= 0; i--) begin
         rd(15'(15'h134 + i), hdr[i], 1'b0, $sformatf("rev%0d", i));
         if (i == 12) begin
            rd(15'h140, ~hdr[12], 1'b0, "dup1");
            rd(15'h140, hdr[12] + 8'd1, 1'b0, "dup2");
         end
      end

      do_reset("rst3");
      mk_hdr(8'h01, 8'h07, 8'h03, 1'b0);
      rd_seq("big");

      do_reset("rst4");
      mk_hdr(8'h03, 8'h02, 8'h01, 1'b0);
      for (int i = 0; i <= 12; i++)
         rd(15'(15'h134 + i), hdr[i], 1'b0, $sformatf("part%0d", i));
      iadr = 15'h141; data = hdr[13]; ics_rom = 1'b1; read = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      m_clear();
      chk_all("rstmid");
      read = 1'b0; ics_rom = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      mk_hdr(8'h13, 8'h01, 8'h02, 1'b0);
      rd_seq("full");

      rd(15'h148, 8'h02, 1'b0, "lock148");
      rd(15'h134, 8'h55, 1'b0, "lock134");

      do_reset("rst5");
      rd(15'h147, 8'h1B, 1'b0, "only147");
      rd(15'h148, 8'h04, 1'b0, "only148");
      rd(15'h149, 8'h02, 1'b0, "only149");

      for (int it = 0; it < 5; it++) begin
         int j, tmp, k;
         do_reset($sformatf("rrst%0d", it));
         mk_hdr(8'($urandom), 8'($urandom_range(0, 8)), 8'($urandom_range(0, 5)),
                bit'($urandom_range(0, 1)));
         for (int i = 0; i < 26; i++) ord[i] = i;
         for (int i = 25; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
         end
         for (int i = 0; i < 26; i++) begin
            rd(15'(15'h134 + ord[i]), hdr[ord[i]], bit'($urandom_range(0, 1)),
               $sformatf("rnd%0d_%0d", it, i));
            if ($urandom_range(0, 3) == 0) begin
               k = ord[$urandom_range(0, i)];
               rd(15'(15'h134 + k), 8'($urandom), 1'b0, $sformatf("rdup%0d_%0d", it, i));
            end
            if ($urandom_range(0, 5) == 0)
               rd(($urandom_range(0, 1) != 0) ? 15'h133 : 15'h14E, 8'($urandom), 1'b0,
                  $sformatf("rout%0d_%0d", it, i));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
